// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared mode, direction and state encodings for the ghost mode scheduler
package ghost_pkg;

   localparam logic [3:0] MODE_CHASE   = 4'b1000;
   localparam logic [3:0] MODE_SCATTER = 4'b0100;
   localparam logic [3:0] MODE_FRIGHT  = 4'b0010;
   localparam logic [3:0] MODE_EATEN   = 4'b0001;

   localparam logic [15:0] DIR_LEFT  = 16'hFF00;
   localparam logic [15:0] DIR_RIGHT = 16'h0100;
   localparam logic [15:0] DIR_UP    = 16'h00FF;
   localparam logic [15:0] DIR_DOWN  = 16'h0001;

   localparam logic [1:0] ST_NORMAL = 2'd0;
   localparam logic [1:0] ST_FRIGHT = 2'd1;
   localparam logic [1:0] ST_EATEN  = 2'd2;

   localparam int TIMER_W = 16;
   typedef logic [TIMER_W-1:0] timer_t;

   // Phase 7 is chase forever, so its duration is never consumed.
   function automatic timer_t phase_duration(input logic [2:0] ph,
                                             input int scatter_short,
                                             input int scatter_long,
                                             input int chase_ticks);
      timer_t d;
      case (ph)
         3'd0, 3'd2: d = timer_t'(scatter_short);
         3'd4, 3'd6: d = timer_t'(scatter_long);
         3'd7:       d = '0;
         default:    d = timer_t'(chase_ticks);
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ghost_mode_fsm.sv
// rtl/ghost_mode_fsm.sv - per-ghost NORMAL/FRIGHT/EATEN state, mode output and reverse request
module ghost_mode_fsm
   import ghost_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] base_mode,
   input  logic       base_changed,
   input  logic       fright_start,
   input  logic       fright_end,
   input  logic       update,
   input  logic       eaten,
   input  logic       home,
   output logic [3:0] mode,
   output logic       rotate
);

   logic [1:0] state;
   logic [1:0] state_next;
   logic       set_rotate;

   always_comb begin
      state_next = state;
      set_rotate = 1'b0;
      case (state)
         ST_NORMAL: begin
            if (fright_start) begin
               state_next = ST_FRIGHT;
               set_rotate = 1'b1;
            end else if (base_changed) begin
               set_rotate = 1'b1;
            end
         end
         ST_FRIGHT: begin
            // Being eaten beats expiry landing on the same tick.
            if (eaten)
               state_next = ST_EATEN;
            else if (fright_end)
               state_next = ST_NORMAL;
         end
         ST_EATEN: begin
            if (home)
               state_next = ST_NORMAL;
         end
         default: state_next = ST_NORMAL;
      endcase
   end

   always_comb begin
      mode = base_mode;
      case (state)
         ST_FRIGHT: mode = MODE_FRIGHT;
         ST_EATEN:  mode = MODE_EATEN;
         default:   mode = base_mode;
      endcase
   end

   // A new request outranks the consume, so one raised on an update cycle lasts to the next update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_NORMAL;
         rotate <= 1'b0;
      end else begin
         state <= state_next;
         if (set_rotate)
            rotate <= 1'b1;
         else if (update)
            rotate <= 1'b0;
      end
   end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - game-tick divider, scatter/chase phase table and shared fright timer
module ghost_mode_scheduler #(
   parameter int TICK_DIV      = 833333,
   parameter int SCATTER_SHORT = 420,
   parameter int SCATTER_LONG  = 300,
   parameter int CHASE_TICKS   = 1200,
   parameter int FRIGHT_TICKS  = 360,
   parameter int WARN_TICKS    = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       power_pellet,
   input  logic [3:0] ghost_eaten,
   input  logic [3:0] ghost_home,
   output logic [3:0] mode0,
   output logic [3:0] mode1,
   output logic [3:0] mode2,
   output logic [3:0] mode3,
   output logic [3:0] rotate,
   output logic       update,
   output logic [2:0] phase,
   output logic       fright_warn
);
   import ghost_pkg::*;

   localparam int DIV_W = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   timer_t           phase_timer;
   timer_t           fright_timer;
   logic             tick;
   logic             frightened;
   logic             phase_step;
   logic             advance;
   logic             fright_end;
   logic [3:0]       base_mode;
   logic [3:0]       mode_vec [4];

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         update  <= 1'b0;
      end else if (enable) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            update  <= 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
            update  <= 1'b0;
         end
      end else begin
         update <= 1'b0;
      end
   end

   assign tick       = update && enable;
   assign frightened = (fright_timer != '0);
   assign phase_step = tick && !frightened && (phase != 3'd7);
   assign advance    = phase_step && (phase_timer == timer_t'(1));
   assign base_mode  = phase[0] ? MODE_CHASE : MODE_SCATTER;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase       <= 3'd0;
         phase_timer <= phase_duration(3'd0, SCATTER_SHORT, SCATTER_LONG, CHASE_TICKS);
      end else if (advance) begin
         phase       <= phase + 3'd1;
         phase_timer <= phase_duration(phase + 3'd1, SCATTER_SHORT, SCATTER_LONG, CHASE_TICKS);
      end else if (phase_step) begin
         phase_timer <= phase_timer - timer_t'(1);
      end
   end

   // A pellet on the expiring tick reloads the timer and must not release the ghosts.
   assign fright_end = tick && (fright_timer == timer_t'(1)) && !power_pellet;

   always_ff @(posedge clk) begin
      if (reset)
         fright_timer <= '0;
      else if (power_pellet)
         fright_timer <= timer_t'(FRIGHT_TICKS);
      else if (tick && frightened)
         fright_timer <= fright_timer - timer_t'(1);
   end

   assign fright_warn = frightened && (fright_timer <= timer_t'(WARN_TICKS));

   for (genvar g = 0; g < 4; g++) begin : g_ghost
      ghost_mode_fsm u_fsm (
         .clk          (clk),
         .reset        (reset),
         .base_mode    (base_mode),
         .base_changed (advance),
         .fright_start (power_pellet),
         .fright_end   (fright_end),
         .update       (update),
         .eaten        (ghost_eaten[g]),
         .home         (ghost_home[g]),
         .mode         (mode_vec[g]),
         .rotate       (rotate[g])
      );
   end

   assign mode0 = mode_vec[0];
   assign mode1 = mode_vec[1];
   assign mode2 = mode_vec[2];
   assign mode3 = mode_vec[3];

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb/tb_ghost_mode_scheduler.sv - directed bench for the ghost mode scheduler
module tb_ghost_mode_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       power_pellet;
   logic [3:0] ghost_eaten;
   logic [3:0] ghost_home;
   logic [3:0] mode0, mode1, mode2, mode3;
   logic [3:0] rotate;
   logic       update;
   logic [2:0] phase;
   logic       fright_warn;
   logic [15:0] modes;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign modes = {mode3, mode2, mode1, mode0};

   ghost_mode_scheduler #(
      .TICK_DIV      (4),
      .SCATTER_SHORT (3),
      .SCATTER_LONG  (2),
      .CHASE_TICKS   (5),
      .FRIGHT_TICKS  (6),
      .WARN_TICKS    (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .power_pellet (power_pellet),
      .ghost_eaten  (ghost_eaten),
      .ghost_home   (ghost_home),
      .mode0        (mode0),
      .mode1        (mode1),
      .mode2        (mode2),
      .mode3        (mode3),
      .rotate       (rotate),
      .update       (update),
      .phase        (phase),
      .fright_warn  (fright_warn)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns immediately if update is already high; n is the number of cycles waited.
   task automatic wait_upd(output int n);
      n = 0;
      while (!update && n < 32) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("update_seen", 32'(update), 32'd1);
   endtask

   // Leaves the bench one cycle after the k-th update, where its effects are visible.
   task automatic run_updates(input int k);
      int n;
      repeat (k) begin
         wait_upd(n);
         step(1);
      end
   endtask

   initial begin
      int n;
      int seen;
      reset = 1'b1; enable = 1'b0; power_pellet = 1'b0;
      ghost_eaten = 4'h0; ghost_home = 4'h0;
      step(3);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_modes", 32'(modes), 32'h4444);
      chk("rst_rotate", 32'(rotate), 32'h0);
      chk("rst_update", 32'(update), 32'd0);
      chk("rst_warn", 32'(fright_warn), 32'd0);
      chk("rst_phase_timer", 32'(dut.phase_timer), 32'd3);
      chk("rst_fright_timer", 32'(dut.fright_timer), 32'd0);

      reset = 1'b0; enable = 1'b1;
      wait_upd(n);
      chk("upd_latency", 32'(n), 32'd4);
      step(1);
      chk("upd_single", 32'(update), 32'd0);
      wait_upd(n);
      chk("upd_period", 32'(n), 32'd3);
      step(1);
      chk("p0_after2_phase", 32'(phase), 32'd0);
      chk("p0_after2_modes", 32'(modes), 32'h4444);
      run_updates(1);
      chk("p1_phase", 32'(phase), 32'd1);
      chk("p1_modes", 32'(modes), 32'h8888);
      chk("p1_rotate_set", 32'(rotate), 32'hF);
      wait_upd(n);
      chk("p1_rotate_held", 32'(rotate), 32'hF);
      step(1);
      chk("p1_rotate_clr", 32'(rotate), 32'h0);
      chk("p1_timer", 32'(dut.phase_timer), 32'd4);

      // fright episode in phase 1
      power_pellet = 1'b1; step(1); power_pellet = 1'b0;
      chk("fr_modes", 32'(modes), 32'h2222);
      chk("fr_rotate", 32'(rotate), 32'hF);
      chk("fr_timer", 32'(dut.fright_timer), 32'd6);
      chk("fr_warn0", 32'(fright_warn), 32'd0);
      run_updates(1);
      chk("fr_rotate_clr", 32'(rotate), 32'h0);
      chk("fr_timer5", 32'(dut.fright_timer), 32'd5);
      chk("fr_phase_paused", 32'(dut.phase_timer), 32'd4);
      run_updates(2);
      chk("fr_warn_at3", 32'(fright_warn), 32'd0);
      run_updates(1);
      chk("fr_warn_at2", 32'(fright_warn), 32'd1);
      chk("fr_modes_at2", 32'(modes), 32'h2222);

      ghost_eaten = 4'b0010; step(1); ghost_eaten = 4'h0;
      chk("eat1_modes", 32'(modes), 32'h2212);
      power_pellet = 1'b1; step(1); power_pellet = 1'b0;
      chk("eat1_pellet_modes", 32'(modes), 32'h2212);
      chk("eat1_pellet_timer", 32'(dut.fright_timer), 32'd6);
      chk("eat1_pellet_rotate", 32'(rotate), 32'h0);
      chk("eat1_pellet_warn", 32'(fright_warn), 32'd0);
      ghost_home = 4'b0010; step(1); ghost_home = 4'h0;
      chk("home1_modes", 32'(modes), 32'h2282);
      chk("home1_rotate", 32'(rotate), 32'h0);
      run_updates(6);
      chk("fr_end_modes", 32'(modes), 32'h8888);
      chk("fr_end_rotate", 32'(rotate), 32'h0);
      chk("fr_end_timer", 32'(dut.fright_timer), 32'd0);
      chk("fr_end_phase", 32'(phase), 32'd1);
      chk("fr_end_phase_timer", 32'(dut.phase_timer), 32'd4);

      // pellet + eaten together: ignored when NORMAL, taken when FRIGHT
      power_pellet = 1'b1; ghost_eaten = 4'b0001; step(1);
      chk("pe_normal_modes", 32'(modes), 32'h2222);
      chk("pe_normal_rotate", 32'(rotate), 32'hF);
      step(1); power_pellet = 1'b0; ghost_eaten = 4'h0;
      chk("pe_fright_modes", 32'(modes), 32'h2221);
      chk("pe_fright_timer", 32'(dut.fright_timer), 32'd6);

      // freeze while disabled; home still processed
      enable = 1'b0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (update) seen++;
         if (i == 10) ghost_home = 4'b0001;
         if (i == 11) ghost_home = 4'h0;
      end
      chk("dis_no_update", 32'(seen), 32'd0);
      chk("dis_fright_timer", 32'(dut.fright_timer), 32'd6);
      chk("dis_phase_timer", 32'(dut.phase_timer), 32'd4);
      chk("dis_div_cnt", 32'(dut.div_cnt), 32'd3);
      chk("dis_home_modes", 32'(modes), 32'h2228);
      enable = 1'b1;

      reset = 1'b1; step(1);
      chk("mid_rst_modes", 32'(modes), 32'h4444);
      chk("mid_rst_phase", 32'(phase), 32'd0);
      chk("mid_rst_rotate", 32'(rotate), 32'h0);
      chk("mid_rst_warn", 32'(fright_warn), 32'd0);
      chk("mid_rst_fright", 32'(dut.fright_timer), 32'd0);
      reset = 1'b0;

      // full phase table: 3+5+3+5 -> phase 4, then 2, 5, 2
      run_updates(16);
      chk("pt_phase4", 32'(phase), 32'd4);
      run_updates(1);
      chk("pt_phase4_hold", 32'(phase), 32'd4);
      run_updates(1);
      chk("pt_phase5", 32'(phase), 32'd5);
      chk("pt_phase5_modes", 32'(modes), 32'h8888);
      run_updates(5);
      chk("pt_phase6", 32'(phase), 32'd6);
      chk("pt_phase6_modes", 32'(modes), 32'h4444);
      run_updates(2);
      chk("pt_phase7", 32'(phase), 32'd7);
      chk("pt_phase7_modes", 32'(modes), 32'h8888);
      chk("pt_phase7_rotate", 32'(rotate), 32'hF);
      run_updates(100);
      chk("pt_hold_phase", 32'(phase), 32'd7);
      chk("pt_hold_modes", 32'(modes), 32'h8888);
      chk("pt_hold_rotate", 32'(rotate), 32'h0);

      // pellet on the expiring tick reloads and keeps ghosts frightened
      power_pellet = 1'b1; step(1); power_pellet = 1'b0;
      run_updates(5);
      chk("re_timer1", 32'(dut.fright_timer), 32'd1);
      chk("re_warn1", 32'(fright_warn), 32'd1);
      wait_upd(n);
      power_pellet = 1'b1; step(1); power_pellet = 1'b0;
      chk("re_reload_timer", 32'(dut.fright_timer), 32'd6);
      chk("re_reload_modes", 32'(modes), 32'h2222);
      chk("re_reload_rotate", 32'(rotate), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
